// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: shares one CBus port between NUM_PORTS cache requesters.
// One grant per transaction, held for the whole burst until ready && last.
//
// Ports:
//   clk, resetn       clock; synchronous active-low reset
//   ireqs[NUM_PORTS]  requests from the caches
//   iresps[NUM_PORTS] responses to the caches (only the granted one is live)
//   oreq              request to the downstream bus
//   oresp             response from the downstream bus
//   busy              high while a granted transaction is in flight
//   grant_idx         index of the granted port, valid while busy
//
// Build option: define CBUS_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins); otherwise round-robin via rr_ptr.

package cbus_pkg;

   typedef enum logic [3:0] {
      MLEN1  = 4'd0,
      MLEN2  = 4'd1,
      MLEN4  = 4'd3,
      MLEN8  = 4'd7,
      MLEN16 = 4'd15
   } cbus_len_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      cbus_len_t   len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

endpackage

module cbus_rr_arbiter
   import cbus_pkg::*;
#(
   parameter int NUM_PORTS = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  cbus_req_t  ireqs  [NUM_PORTS],
   output cbus_resp_t iresps [NUM_PORTS],
   output cbus_req_t  oreq,
   input  cbus_resp_t oresp,
   output logic       busy,
   output logic [$clog2(NUM_PORTS)-1:0] grant_idx
);

   localparam int IDX_BITS = $clog2(NUM_PORTS);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [IDX_BITS-1:0] grant_nxt;
   logic [IDX_BITS-1:0] grant_inc;
   logic [IDX_BITS-1:0] win_idx;
   logic                win_found;
   logic                beat_seen;
   logic                beat_seen_nxt;
   logic                done;
   logic [NUM_PORTS-1:0] req_valid;
   cbus_req_t           gnt_req;

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         req_valid[i] = ireqs[i].valid;
      end
   end

   assign gnt_req = ireqs[grant_idx];
   assign done    = oresp.ready && oresp.last;

   // pointer just past the current grant, wrapping at NUM_PORTS
   always_comb begin
      grant_inc = grant_idx + IDX_BITS'(1);
      if (grant_idx == IDX_BITS'(NUM_PORTS - 1)) begin
         grant_inc = '0;
      end
   end

`ifdef CBUS_ARB_FIXED_PRIO_EN

   // descending scan: the lowest valid index is written last and wins
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            win_found = 1'b1;
            win_idx   = IDX_BITS'(i);
         end
      end
   end

`else

   logic [IDX_BITS-1:0] rr_ptr;
   logic [IDX_BITS-1:0] rr_nxt;
   logic [IDX_BITS-1:0] cand;
   logic [IDX_BITS:0]   rr_sum;

   // scan rr_ptr+k (mod NUM_PORTS) for descending k so that the
   // smallest offset from rr_ptr is the one that sticks
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      rr_sum    = '0;
      cand      = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         rr_sum = {1'b0, rr_ptr} + (IDX_BITS+1)'(k);
         if (rr_sum >= (IDX_BITS+1)'(NUM_PORTS)) begin
            rr_sum = rr_sum - (IDX_BITS+1)'(NUM_PORTS);
         end
         cand = rr_sum[IDX_BITS-1:0];
         if (req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // granted port drops to lowest priority only on a real completion
   always_comb begin
      rr_nxt = rr_ptr;
      if (state == BUSY && done) begin
         rr_nxt = grant_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rr_ptr <= '0;
      end else begin
         rr_ptr <= rr_nxt;
      end
   end

`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         grant_idx <= '0;
         beat_seen <= 1'b0;
      end else begin
         state     <= state_nxt;
         grant_idx <= grant_nxt;
         beat_seen <= beat_seen_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant_idx;
      beat_seen_nxt = beat_seen;
      oreq          = '0;
      busy          = 1'b0;
      unique case (state)
         IDLE: begin
            beat_seen_nxt = 1'b0;
            if (win_found) begin
               state_nxt = BUSY;
               grant_nxt = win_idx;
            end
         end
         BUSY: begin
            busy = 1'b1;
            oreq = gnt_req;
            if (done) begin
               state_nxt     = IDLE;
               beat_seen_nxt = 1'b0;
            end else if (oresp.ready) begin
               beat_seen_nxt = 1'b1;
            end else if (!gnt_req.valid && !beat_seen) begin
               // abandoned before any data moved
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // only the granted port ever sees ready/last
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         iresps[i] = '0;
         if (state == BUSY && grant_idx == IDX_BITS'(i)) begin
            iresps[i] = oresp;
         end
      end
   end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: scoreboard bench for cbus_rr_arbiter, two ports.
// Downstream model returns addr^beat per beat under a ready pattern.

module tb_cbus_rr_arbiter;
   import cbus_pkg::*;

   localparam int NP = 2;

   logic       clk = 1'b0;
   logic       resetn;
   cbus_req_t  ireqs  [NP];
   cbus_resp_t iresps [NP];
   cbus_req_t  oreq;
   cbus_resp_t oresp;
   logic       busy;
   logic [0:0] grant_idx;

   always #5 clk = ~clk;

   cbus_rr_arbiter #(.NUM_PORTS(NP)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .ireqs     (ireqs),
      .iresps    (iresps),
      .oreq      (oreq),
      .oresp     (oresp),
      .busy      (busy),
      .grant_idx (grant_idx)
   );

   typedef struct {
      int          port;
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   bit   drop_pend [NP];
   int   bcnt [NP];
   bit [15:0] ds_pat = 16'hffff;
   bit   ds_act = 1'b0;
   int   ds_left, ds_beat, ds_pidx;

   task automatic check(input string tag, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic ds_step();
      oresp = '0;
      if (!oreq.valid) begin
         ds_act = 1'b0;
      end else begin
         if (!ds_act) begin
            ds_act  = 1'b1;
            ds_left = int'(oreq.len) + 1;
            ds_beat = 0;
            ds_pidx = 0;
         end
         if (ds_pat[ds_pidx % 16]) begin
            oresp.ready = 1'b1;
            oresp.last  = (ds_left == 1);
            oresp.data  = oreq.addr ^ 32'(ds_beat);
            ds_left--;
            ds_beat++;
            if (ds_left == 0) ds_act = 1'b0;
         end
         ds_pidx++;
      end
   endtask

   task automatic mon_step();
      exp_t e;
      for (int i = 0; i < NP; i++) begin
         if (iresps[i].ready) begin
            bcnt[i]++;
            if (sb.size() == 0) begin
               check("sb_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               check("beat_port", i, e.port);
               check("beat_data", iresps[i].data, e.data);
               check("beat_last", iresps[i].last, e.last);
            end
            if (iresps[i].last) drop_pend[i] = 1'b1;
         end
         if (!(busy && grant_idx == 1'(i))) begin
            check("resp_leak", iresps[i], 0);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
         if (drop_pend[i]) begin
            ireqs[i].valid = 1'b0;
            drop_pend[i]   = 1'b0;
         end
      end
      #1 ds_step();
      #1 mon_step();
   endtask

   task automatic issue(input int p, input logic wr,
                        input logic [31:0] addr, input cbus_len_t len,
                        input logic [3:0] strb, input logic [31:0] data);
      ireqs[p].valid    = 1'b1;
      ireqs[p].is_write = wr;
      ireqs[p].size     = 3'd2;
      ireqs[p].addr     = addr;
      ireqs[p].strobe   = strb;
      ireqs[p].data     = data;
      ireqs[p].len      = len;
   endtask

   task automatic push_exp(input int p, input logic [31:0] addr,
                           input cbus_len_t len, input int n);
      exp_t e;
      for (int b = 0; b < n; b++) begin
         e.port = p;
         e.data = addr ^ 32'(b);
         e.last = (b == int'(len));
         sb.push_back(e);
      end
   endtask

   task automatic wait_done(input int p);
      int n = 0;
      while (ireqs[p].valid && n < 64) begin
         tick();
         n++;
      end
      check("done_timeout", ireqs[p].valid, 0);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      for (int i = 0; i < NP; i++) begin
         ireqs[i]     = '0;
         drop_pend[i] = 1'b0;
      end
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_gnt", grant_idx, 0);
      check("rst_oreq", oreq, 0);
      check("rst_resp0", iresps[0], 0);
      check("rst_resp1", iresps[1], 0);
      resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b0;
      oresp  = '0;
      for (int i = 0; i < NP; i++) begin
         ireqs[i] = '0;
         bcnt[i]  = 0;
      end
      do_reset();

      // single port 4-beat read
      issue(0, 1'b0, 32'h1fc00000, MLEN4, 4'h0, 32'h0);
      push_exp(0, 32'h1fc00000, MLEN4, 4);
      tick();
      check("t1_busy", busy, 1);
      check("t1_gnt", grant_idx, 0);
      check("t1_addr", oreq.addr, 32'h1fc00000);
      wait_done(0);
      check("t1_idle", busy, 0);

      // both ports from reset, then re-contend
      do_reset();
      issue(0, 1'b0, 32'h00001000, MLEN2, 4'h0, 32'h0);
      issue(1, 1'b0, 32'h00002000, MLEN2, 4'h0, 32'h0);
      push_exp(0, 32'h00001000, MLEN2, 2);
`ifndef CBUS_ARB_FIXED_PRIO_EN
      push_exp(1, 32'h00002000, MLEN2, 2);
`endif
      tick();
      check("t2_busy", busy, 1);
      check("t2_gnt_a", grant_idx, 0);
      wait_done(0);
      check("t2_gap", busy, 0);
      issue(0, 1'b0, 32'h00003000, MLEN2, 4'h0, 32'h0);
      push_exp(0, 32'h00003000, MLEN2, 2);
`ifdef CBUS_ARB_FIXED_PRIO_EN
      push_exp(1, 32'h00002000, MLEN2, 2);
`endif
      tick();
      check("t2_busy_b", busy, 1);
`ifdef CBUS_ARB_FIXED_PRIO_EN
      check("t2_gnt_b", grant_idx, 0);
`else
      check("t2_gnt_b", grant_idx, 1);
`endif
      wait_done(0);
      wait_done(1);

      // uncached write waits behind a burst
      issue(0, 1'b0, 32'h80000100, MLEN8, 4'h0, 32'h0);
      push_exp(0, 32'h80000100, MLEN8, 8);
      tick();
      check("t3_gnt0", grant_idx, 0);
      tick();
      issue(1, 1'b1, 32'h1fd00004, MLEN1, 4'b0011, 32'hdeadbeef);
      push_exp(1, 32'h1fd00004, MLEN1, 1);
      for (int n = 0; n < 64 && ireqs[0].valid; n++) begin
         tick();
         if (ireqs[0].valid) begin
            check("t3_hold_gnt", grant_idx, 0);
            check("t3_hold_addr", oreq.addr, 32'h80000100);
         end
      end
      check("t3_p0_done", ireqs[0].valid, 0);
      check("t3_gap", busy, 0);
      tick();
      check("t3_busy", busy, 1);
      check("t3_gnt1", grant_idx, 1);
      check("t3_wr", oreq.is_write, 1);
      check("t3_strb", oreq.strobe, 4'b0011);
      check("t3_data", oreq.data, 32'hdeadbeef);
      check("t3_addr", oreq.addr, 32'h1fd00004);
      wait_done(1);

      // downstream stalls: ready 1,0,0,1,1,0,1
      ds_pat  = 16'hffd9;
      bcnt[0] = 0;
      issue(0, 1'b0, 32'h00004000, MLEN4, 4'h0, 32'h0);
      push_exp(0, 32'h00004000, MLEN4, 4);
      for (int c = 0; c < 7; c++) begin
         tick();
         check("t4_busy", busy, 1);
         check("t4_gnt", grant_idx, 0);
      end
      tick();
      check("t4_idle", busy, 0);
      check("t4_beats", bcnt[0], 4);
      check("t4_drop", ireqs[0].valid, 0);
      ds_pat = 16'hffff;

      // reset during beat 2
      issue(0, 1'b0, 32'h00005000, MLEN4, 4'h0, 32'h0);
      push_exp(0, 32'h00005000, MLEN4, 2);
      tick();
      tick();
      resetn   = 1'b0;
      ireqs[0] = '0;
      tick();
      check("t5_busy", busy, 0);
      check("t5_ovalid", oreq.valid, 0);
      check("t5_gnt", grant_idx, 0);
      resetn = 1'b1;
      issue(1, 1'b0, 32'h00006000, MLEN1, 4'h0, 32'h0);
      push_exp(1, 32'h00006000, MLEN1, 1);
      tick();
      check("t5_busy2", busy, 1);
      check("t5_gnt2", grant_idx, 1);
      wait_done(1);

      // granted port drops before any ready beat
      ds_pat = 16'h0000;
      issue(0, 1'b0, 32'h00007000, MLEN4, 4'h0, 32'h0);
      issue(1, 1'b0, 32'h00007100, MLEN2, 4'h0, 32'h0);
      push_exp(1, 32'h00007100, MLEN2, 2);
      tick();
      check("t6_busy", busy, 1);
      check("t6_gnt0", grant_idx, 0);
      ireqs[0].valid = 1'b0;
      ds_pat = 16'hffff;
      tick();
      check("t6_drop_idle", busy, 0);
      tick();
      check("t6_busy1", busy, 1);
      check("t6_gnt1", grant_idx, 1);
      wait_done(1);

      // drop must leave rr_ptr alone
      ds_pat = 16'h0000;
      issue(0, 1'b0, 32'h00007200, MLEN1, 4'h0, 32'h0);
      tick();
      check("t7_gnt0", grant_idx, 0);
      ireqs[0].valid = 1'b0;
      ds_pat = 16'hffff;
      tick();
      check("t7_idle", busy, 0);
      issue(0, 1'b0, 32'h00007300, MLEN1, 4'h0, 32'h0);
      issue(1, 1'b0, 32'h00007400, MLEN1, 4'h0, 32'h0);
      push_exp(0, 32'h00007300, MLEN1, 1);
      push_exp(1, 32'h00007400, MLEN1, 1);
      tick();
      check("t7_rr_kept", grant_idx, 0);
      wait_done(0);
      wait_done(1);

      tick();
      check("sb_left", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
